// File: rtl/tx_symbols_pkg.sv
// Symbol codes and framer state encoding for the TX/RX symbol path.
// Shared by the TX framer and the RX deframer.
package tx_symbols_pkg;

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] K_STP  = 8'hFB;
    localparam logic [7:0] K_SDP  = 8'h5C;
    localparam logic [7:0] K_END  = 8'hFD;
    localparam logic [7:0] K_EDB  = 8'hFE;
    localparam logic [7:0] K_FTS  = 8'h3C;
    localparam logic [7:0] K_IDLE = 8'h00;

    localparam int FTS_SET_LEN = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_END,
        ST_DROP,
        ST_SKP_COM,
        ST_SKP_SYM,
        ST_FTS_COM,
        ST_FTS_SYM
    } tx_state_e;

endpackage

// File: rtl/tx_symbol_framer_skp_timer.sv
// SKP interval timer: one-cycle tick every SKP_INTERVAL enabled cycles.
// The framer owns the pending flag; this block only counts.
module skp_timer #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    output logic tick
);

    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = enb && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (enb) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_symbol_framer.sv
// TX symbol framer: packet framing, SKP/FTS ordered-set insertion,
// valid/ready intake with underrun nullification; registered output.
module tx_symbol_framer
    import tx_symbols_pkg::*;
#(
    parameter int SYM_W        = 8,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3,
    parameter int N_FTS        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [SYM_W-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_sop,
    input  logic             s_eop,
    input  logic             s_dllp,
    input  logic             s_bad,
    output logic             s_ready,
    input  logic             fts_req,
    output logic [SYM_W-1:0] tx_multiplexada,
    output logic             tx_ValidS,
    output logic             tx_underrun
);

    localparam int CNT_W = $clog2(N_FTS * FTS_SET_LEN + 1);
    localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_LEN - 1);
    localparam logic [CNT_W-1:0] FTS_LAST = CNT_W'(N_FTS * FTS_SET_LEN - 1);

    localparam logic [SYM_W-1:0] C_COM  = SYM_W'(K_COM);
    localparam logic [SYM_W-1:0] C_SKP  = SYM_W'(K_SKP);
    localparam logic [SYM_W-1:0] C_STP  = SYM_W'(K_STP);
    localparam logic [SYM_W-1:0] C_SDP  = SYM_W'(K_SDP);
    localparam logic [SYM_W-1:0] C_END  = SYM_W'(K_END);
    localparam logic [SYM_W-1:0] C_EDB  = SYM_W'(K_EDB);
    localparam logic [SYM_W-1:0] C_FTS  = SYM_W'(K_FTS);
    localparam logic [SYM_W-1:0] C_IDLE = SYM_W'(K_IDLE);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skp_pend_q, skp_pend_d;
    logic             fts_pend_q, fts_pend_d;
    logic             dllp_q, dllp_d;
    logic             bad_q, bad_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             valid_q, valid_d;
    logic             urun_q, urun_d;
    logic             skp_tick;

    skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk (clk),
        .rst (rst),
        .enb (enb),
        .tick(skp_tick)
    );

    assign s_ready = enb && (state_q == ST_DATA || state_q == ST_DROP);

    assign tx_multiplexada = sym_q;
    assign tx_ValidS       = valid_q;
    assign tx_underrun     = urun_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        skp_pend_d = skp_pend_q;
        fts_pend_d = fts_pend_q;
        dllp_d     = dllp_q;
        bad_d      = bad_q;
        sym_d      = sym_q;
        valid_d    = valid_q;
        urun_d     = 1'b0;
        if (enb) begin
            sym_d   = C_IDLE;
            valid_d = 1'b1;
            if (fts_req) begin
                fts_pend_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (skp_pend_q) begin
                        state_d = ST_SKP_COM;
                    end else if (fts_pend_q) begin
                        state_d = ST_FTS_COM;
                    end else if (s_valid && s_sop) begin
                        dllp_d  = s_dllp;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    sym_d   = dllp_q ? C_SDP : C_STP;
                    valid_d = 1'b0;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (s_valid) begin
                        sym_d = s_data;
                        if (s_eop) begin
                            bad_d   = s_bad;
                            state_d = ST_END;
                        end
                    end else begin
                        sym_d   = C_EDB;
                        valid_d = 1'b0;
                        urun_d  = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_END: begin
                    sym_d   = bad_q ? C_EDB : C_END;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_DROP: begin
                    if (s_valid && s_eop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SKP_COM: begin
                    sym_d      = C_COM;
                    valid_d    = 1'b0;
                    skp_pend_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_SKP_SYM;
                end
                ST_SKP_SYM: begin
                    sym_d   = C_SKP;
                    valid_d = 1'b0;
                    if (cnt_q == SKP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_FTS_COM: begin
                    sym_d   = C_COM;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_FTS_SYM;
                end
                ST_FTS_SYM: begin
                    sym_d   = C_FTS;
                    valid_d = 1'b0;
                    // cnt runs across the whole burst; low bits mark set boundaries
                    if (cnt_q == FTS_LAST) begin
                        cnt_d      = '0;
                        fts_pend_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q[1:0] == 2'd3) begin
                            state_d = ST_FTS_COM;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (skp_tick) begin
                skp_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            skp_pend_q <= 1'b0;
            fts_pend_q <= 1'b0;
            dllp_q     <= 1'b0;
            bad_q      <= 1'b0;
            sym_q      <= '0;
            valid_q    <= 1'b1;
            urun_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            skp_pend_q <= skp_pend_d;
            fts_pend_q <= fts_pend_d;
            dllp_q     <= dllp_d;
            bad_q      <= bad_d;
            sym_q      <= sym_d;
            valid_q    <= valid_d;
            urun_q     <= urun_d;
        end
    end

endmodule
